// File: rtl/aes_ctr_pkg.sv
// Shared constants and helpers for the CTR keystream XOR stage.
package aes_ctr_pkg;

  localparam int unsigned BLOCK_W      = 128;
  localparam int unsigned DEF_PIPE_LAT = 21;
  localparam int unsigned DEF_KS_DEPTH = 4;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int unsigned credit_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Keep mask for a partial block: byte 0 is bits 127:120, nbytes of 0 means a full block.
  function automatic logic [BLOCK_W-1:0] byte_keep_mask(input logic [4:0] nbytes);
    logic [BLOCK_W-1:0] m;
    int unsigned        n;
    n = (nbytes == 5'd0 || nbytes > 5'd16) ? 16 : {27'd0, nbytes};
    m = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      m[BLOCK_W-1-8*i -: 8] = (i < n) ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/ks_fifo.sv
// Keystream buffer: DEPTH x W synchronous FIFO, registered read (no fall-through).
module ks_fifo
  import aes_ctr_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_KS_DEPTH,
  parameter int unsigned W     = BLOCK_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          wr_en;
  logic          rd_en;

  // Guard the pointers: a push into a full FIFO only lands if a pop frees a slot.
  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    wr_en    = push && (!full || pop);
    rd_en    = pop && !empty;
    pop_data = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ctr_keystream_xor.sv
// CTR keystream capture, credit-based launch control and plaintext XOR output stage.
// Optional build macro CTR_PARTIAL_BLOCK_EN adds pt_nbytes and zeroes unused tail bytes.
module ctr_keystream_xor
  import aes_ctr_pkg::*;
#(
  parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
  parameter int unsigned KS_DEPTH = DEF_KS_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_input,
  output logic               scan_output,
  input  logic               scan_ck_en,
  input  logic               scan_enable,
  input  logic               launch_valid,
  output logic               launch_ready,
  input  logic [BLOCK_W-1:0] keystream_in,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [BLOCK_W-1:0] pt_data,
`ifdef CTR_PARTIAL_BLOCK_EN
  input  logic [4:0]         pt_nbytes,
`endif
  output logic               ct_valid,
  input  logic               ct_ready,
  output logic [BLOCK_W-1:0] ct_data,
  output logic               overflow
);

  localparam int unsigned CW = credit_w(KS_DEPTH);

  logic [PIPE_LAT-1:0] tags;
  logic [PIPE_LAT:0]   tags_ext;
  logic [CW-1:0]       credit;
  logic [CW-1:0]       ks_count;
  logic                launch_fire;
  logic                ks_push;
  logic                ks_pop;
  logic                ks_full;
  logic                ks_empty;
  logic [BLOCK_W-1:0]  ks_head;
  logic [BLOCK_W-1:0]  ct_next;
  logic                ct_valid_q;

  // Handshake decode; scan mode masks every handshake output.
  always_comb begin
    launch_ready = !scan_enable && (credit != '0);
    launch_fire  = launch_valid && launch_ready;
    pt_ready     = !scan_enable && !ks_empty && (!ct_valid_q || ct_ready);
    ks_pop       = pt_valid && pt_ready;
    ks_push      = !scan_enable && tags[PIPE_LAT-1] && (!ks_full || ks_pop);
    ct_valid     = ct_valid_q && !scan_enable;
    scan_output  = ct_data[BLOCK_W-1];
    tags_ext     = {tags, launch_fire};
`ifdef CTR_PARTIAL_BLOCK_EN
    ct_next      = (ks_head ^ pt_data) & byte_keep_mask(pt_nbytes);
`else
    ct_next      = ks_head ^ pt_data;
`endif
  end

  // Launch tag pipeline mirrors the AES round pipeline; MSB marks keystream arrival.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tags <= '0;
    else if (!scan_enable) tags <= tags_ext[PIPE_LAT-1:0];
  end

  // Credit = free FIFO slots not already claimed by an in-flight launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit   <= CW'(KS_DEPTH);
      overflow <= 1'b0;
    end else if (!scan_enable) begin
      case ({launch_fire, ks_pop})
        2'b10:   credit <= credit - CW'(1);
        2'b01:   credit <= credit + CW'(1);
        default: credit <= credit;
      endcase
      if (launch_valid && credit == '0) overflow <= 1'b1;
    end
  end

  // Output register doubles as the scan chain; loads on a plaintext handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ct_data    <= '0;
      ct_valid_q <= 1'b0;
    end else if (scan_enable) begin
      if (scan_ck_en) ct_data <= {ct_data[BLOCK_W-2:0], scan_input};
    end else if (ks_pop) begin
      ct_data    <= ct_next;
      ct_valid_q <= 1'b1;
    end else if (ct_valid_q && ct_ready) begin
      ct_valid_q <= 1'b0;
    end
  end

  ks_fifo #(
    .DEPTH (KS_DEPTH),
    .W     (BLOCK_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ks_push),
    .push_data (keystream_in),
    .pop       (ks_pop),
    .pop_data  (ks_head),
    .full      (ks_full),
    .empty     (ks_empty),
    .count     (ks_count)
  );

  // Buffered plus free-credit slots never exceed the FIFO depth.
  credit_bound_a : assert property (@(posedge clk) disable iff (rst)
    (int'(credit) + int'(ks_count)) <= int'(KS_DEPTH));

endmodule

// File: tb/tb_ctr_keystream_xor.sv
// Directed bench for ctr_keystream_xor with a behavioural AES pipeline keystream source.
module tb_ctr_keystream_xor;

  localparam int          PL   = 21;
  localparam logic [127:0] KS0  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] JUNK = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         scan_input = 1'b0;
  logic         scan_output;
  logic         scan_ck_en = 1'b0;
  logic         scan_enable = 1'b0;
  logic         launch_valid = 1'b0;
  logic         launch_ready;
  logic [127:0] keystream_in = JUNK;
  logic         pt_valid = 1'b0;
  logic         pt_ready;
  logic [127:0] pt_data = '0;
`ifdef CTR_PARTIAL_BLOCK_EN
  logic [4:0]   pt_nbytes = 5'd0;
`endif
  logic         ct_valid;
  logic         ct_ready = 1'b0;
  logic [127:0] ct_data;
  logic         overflow;

  int n_vec  = 0;
  int n_miss = 0;

  ctr_keystream_xor dut (
    .clk          (clk),
    .rst          (rst),
    .scan_input   (scan_input),
    .scan_output  (scan_output),
    .scan_ck_en   (scan_ck_en),
    .scan_enable  (scan_enable),
    .launch_valid (launch_valid),
    .launch_ready (launch_ready),
    .keystream_in (keystream_in),
    .pt_valid     (pt_valid),
    .pt_ready     (pt_ready),
    .pt_data      (pt_data),
`ifdef CTR_PARTIAL_BLOCK_EN
    .pt_nbytes    (pt_nbytes),
`endif
    .ct_valid     (ct_valid),
    .ct_ready     (ct_ready),
    .ct_data      (ct_data),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ks_of(input int n);
    logic [7:0] b;
    b = n[7:0];
    return KS0 ^ {16{b}};
  endfunction

  function automatic logic [127:0] pt_of(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {8{b, 8'h5A}};
  endfunction

  // Upstream AES model: every launch_valid pulse produces keystream PL cycles later,
  // whether or not the DUT granted credit.
  logic pv [PL];
  int   pid [PL];
  int   next_id = 0;
  initial for (int i = 0; i < PL; i++) begin pv[i] = 1'b0; pid[i] = 0; end

  always @(posedge clk) begin
    for (int i = PL - 1; i > 0; i--) begin
      pv[i]  = pv[i-1];
      pid[i] = pid[i-1];
    end
    pv[0]  = launch_valid;
    pid[0] = next_id;
    if (launch_valid) next_id = next_id + 1;
    keystream_in <= pv[PL-1] ? ks_of(pid[PL-1]) : JUNK;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic launch(input int n);
    for (int i = 0; i < n; i++) begin
      launch_valid = 1'b1;
      step();
    end
    launch_valid = 1'b0;
  endtask

  // Present one plaintext block, wait (bounded) for acceptance, check the result.
  task automatic take(input string tag, input logic [127:0] pt, input logic [127:0] exp);
    int n;
    n = 0;
    pt_valid = 1'b1;
    pt_data  = pt;
    ct_ready = 1'b1;
    #1;
    while (!pt_ready && n < 60) begin
      step();
      n++;
    end
    if (!pt_ready) check({tag, "_timeout"}, 128'd0, 128'd1);
    step();
    pt_valid = 1'b0;
    check(tag, ct_data, exp);
    check({tag, "_vld"}, {127'd0, ct_valid}, 128'd1);
  endtask

  initial begin
    int n;
    int base;
    int nl, npt, nct, cyc;

    // Reset state
    idle(3);
    check("rst_lr",   {127'd0, launch_ready}, 128'd1);
    rst = 1'b0;
    #1;
    check("rst_lr2",  {127'd0, launch_ready}, 128'd1);
    check("rst_ctv",  {127'd0, ct_valid},     128'd0);
    check("rst_ovf",  {127'd0, overflow},     128'd0);
    check("rst_ptr",  {127'd0, pt_ready},     128'd0);
    check("rst_ctd",  ct_data,                128'd0);
    idle(2);

    // Single launch: keystream captured at cycle 21, readable at cycle 22
    launch_valid = 1'b1;
    step();
    launch_valid = 1'b0;
    n = 1;
    while (!pt_ready && n < 60) begin
      step();
      n++;
    end
    check("single_lat", 128'(n), 128'd22);
    pt_valid = 1'b1;
    pt_data  = {16{8'hFF}};
    step();
    pt_valid = 1'b0;
    check("single_ct",  ct_data, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    check("single_vld", {127'd0, ct_valid}, 128'd1);
    check("single_ptr", {127'd0, pt_ready}, 128'd0);
    ct_ready = 1'b1;
    step();
    check("single_drop", {127'd0, ct_valid}, 128'd0);
    check("single_hold", ct_data, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    ct_ready = 1'b0;

    // Credit exhaustion and overflow
    base = next_id;
    for (int k = 0; k < 4; k++) begin
      check("cr_lr_pre", {127'd0, launch_ready}, 128'd1);
      launch_valid = 1'b1;
      step();
    end
    launch_valid = 1'b0;
    check("cr_lr_zero", {127'd0, launch_ready}, 128'd0);
    check("cr_ovf_pre", {127'd0, overflow},     128'd0);
    launch(1);
    check("cr_ovf_set", {127'd0, overflow}, 128'd1);
    idle(30);
    check("cr_count", 128'(dut.u_fifo.count), 128'd4);
    for (int k = 0; k < 4; k++) take("cr_take", pt_of(k), ks_of(base + k) ^ pt_of(k));
    step();
    check("cr_no5th",   {127'd0, pt_ready}, 128'd0);
    check("cr_ovf_stk", {127'd0, overflow}, 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("cr_ovf_clr", {127'd0, overflow},     128'd0);
    check("cr_lr_back", {127'd0, launch_ready}, 128'd1);
    idle(30);

    // Stream of 8 blocks with ct_ready toggling
    base = next_id;
    nl = 0; npt = 0; nct = 0; cyc = 0;
    while (nct < 8 && cyc < 400) begin
      ct_ready     = (cyc % 2 == 0);
      launch_valid = (nl < 8) && launch_ready;
      pt_valid     = (npt < 8);
      pt_data      = pt_of(npt);
      #1;
      if (launch_valid) nl++;
      if (pt_valid && pt_ready) npt++;
      if (ct_valid && ct_ready) begin
        check("stream_ct", ct_data, ks_of(base + nct) ^ pt_of(nct));
        nct++;
      end
      step();
      cyc++;
    end
    launch_valid = 1'b0;
    pt_valid     = 1'b0;
    ct_ready     = 1'b1;
    step();
    check("stream_n",      128'(nct),                 128'd8);
    check("stream_credit", 128'(dut.credit),          128'd4);
    check("stream_lr",     {127'd0, launch_ready},    128'd1);
    check("stream_ovf",    {127'd0, overflow},        128'd0);
    check("stream_ctv",    {127'd0, ct_valid},        128'd0);

    // Scan shift with two buffered keystream blocks; launches during scan are frozen out
    base = next_id;
    launch(2);
    idle(30);
    check("scan_cnt_pre", 128'(dut.u_fifo.count), 128'd2);
    scan_enable = 1'b1;
    scan_ck_en  = 1'b1;
    for (int i = 0; i < 128; i++) begin
      scan_input   = (i % 2 == 0);
      launch_valid = (i < 3);
      #1;
      if (i == 0) begin
        check("scan_lr",  {127'd0, launch_ready}, 128'd0);
        check("scan_ptr", {127'd0, pt_ready},     128'd0);
        check("scan_ctv", {127'd0, ct_valid},     128'd0);
      end
      step();
    end
    launch_valid = 1'b0;
    check("scan_data", ct_data, {16{8'hAA}});
    check("scan_out",  {127'd0, scan_output}, 128'd1);
    scan_enable = 1'b0;
    scan_ck_en  = 1'b0;
    #1;
    check("scan_cnt_post", 128'(dut.u_fifo.count), 128'd2);
    check("scan_credit",   128'(dut.credit),        128'd2);
    check("scan_ovf",      {127'd0, overflow},      128'd0);
    check("scan_ptr_post", {127'd0, pt_ready},      128'd1);
    take("scan_take0", pt_of(40), ks_of(base)     ^ pt_of(40));
    take("scan_take1", pt_of(41), ks_of(base + 1) ^ pt_of(41));
    step();
    check("scan_empty", {127'd0, pt_ready}, 128'd0);

    // Reset mid-flight: late keystream must be ignored
    launch(1);
    idle(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(30);
    check("mid_ptr",   {127'd0, pt_ready},      128'd0);
    check("mid_cnt",   128'(dut.u_fifo.count),  128'd0);
    check("mid_lr",    {127'd0, launch_ready},  128'd1);
    check("mid_ctd",   ct_data,                 128'd0);

`ifdef CTR_PARTIAL_BLOCK_EN
    // Partial block: 5 bytes kept, tail zeroed
    base = next_id;
    launch(2);
    idle(25);
    pt_nbytes = 5'd5;
    take("part5", pt_of(7), (ks_of(base) ^ pt_of(7)) & {{40{1'b1}}, 88'd0});
    pt_nbytes = 5'd0;
    take("part16", pt_of(8), ks_of(base + 1) ^ pt_of(8));
    step();
    check("part_empty", {127'd0, pt_ready}, 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ctr_keystream_xor.md
Name: ctr_keystream_xor

Overview:
- Downstream consumer of the AES final round output in the CTR datapath.
- Tracks counter blocks launched into the round pipeline and captures each keystream block when it emerges.
- Buffers keystream blocks, pairs each with an incoming plaintext block, and emits the ciphertext (keystream XOR plaintext) over a valid/ready interface.
- Issues launch credit upstream so keystream is never lost.

Parameters:
- PIPE_LAT, 21: cycles from launch_valid to the matching keystream appearing on keystream_in (range 1..64).
- KS_DEPTH, 4: keystream FIFO entries (power of two, 2..16).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- scan_input  in  1  scan chain serial in.
- scan_output  out  1  scan chain serial out, equals ct_data[127].
- scan_ck_en  in  1  scan shift enable.
- scan_enable  in  1  scan mode select.
- launch_valid  in  1  counter block entered the AES pipeline this cycle.
- launch_ready  out  1  credit available; launch permitted this cycle.
- keystream_in  in  128  final-round state output.
- pt_valid  in  1  plaintext block valid.
- pt_ready  out  1  plaintext accepted when pt_valid && pt_ready.
- pt_data  in  128  plaintext block.
- ct_valid  out  1  ciphertext block valid.
- ct_ready  in  1  downstream accepts.
- ct_data  out  128  ciphertext block.
- overflow  out  1  sticky: launch attempted without credit.

Behaviour:
- Reset (async, rst=1):
  - launch tag shift register cleared; FIFO empty; credit counter = KS_DEPTH.
  - ct_valid=0, ct_data=0, overflow=0, launch_ready=1, pt_ready=0.
- Launch tracking:
  - A PIPE_LAT-bit tag shift register shifts every functional cycle, with bit 0 = launch_valid && launch_ready.
  - When the tag MSB is 1, keystream_in is written into the FIFO on that clock edge.
- Credit:
  - credit = KS_DEPTH − (tags in flight + FIFO occupancy); launch_ready = (credit != 0).
  - Same-cycle launch and FIFO pop leave credit unchanged.
  - Launch with launch_ready=0: launch is ignored (no tag) and overflow is set until reset.
- Pairing:
  - pt_ready = FIFO non-empty && (!ct_valid || ct_ready).
  - On a pt handshake: FIFO pops; next cycle ct_data = fifo_head ^ pt_data and ct_valid=1. Latency is 1 cycle.
  - ct_valid && ct_ready with no new handshake → ct_valid=0 and ct_data holds.
  - Simultaneous ct handshake and pt handshake → new block is loaded with no bubble; full throughput is 1 block/cycle.
- FIFO:
  - Write when full is impossible while credit is respected.
  - Push and pop in the same cycle are both honoured.
  - When empty, a pushed entry is readable the following cycle (no fall-through).
- Scan (scan_enable=1):
  - All functional state freezes, including tags, FIFO, credit and overflow.
  - When scan_ck_en=1, ct_data shifts {ct_data[126:0], scan_input}.
  - Handshake outputs are forced to 0: launch_ready, pt_ready, ct_valid.
- Reset mid-operation discards all in-flight tags and buffered data. Keystream arriving after reset is ignored.

Optional Feature:
- CTR_PARTIAL_BLOCK_EN defined:
  - Adds input pt_nbytes[4:0], sampled with pt_data (0 means 16).
  - ct_data bytes at index ≥ pt_nbytes (byte 0 = bits 127:120) are forced to 0.
  - Keystream is still consumed.
- Not defined: port absent; every block is a full 16 bytes.

Decomposition:
- Package aes_ctr_pkg:
  - BLOCK_W=128.
  - Default PIPE_LAT and KS_DEPTH constants.
  - Credit counter width function clog2(KS_DEPTH+1).
- Sub-module ks_fifo: synchronous KS_DEPTH×128 FIFO with async reset, push/pop/full/empty/count.
- Tag register, credit counter, output register and scan mux stay in the top module.

Test Plan:
- Reset → launch_ready=1, ct_valid=0, overflow=0, ct_data=0.
- Single launch at cycle 0; keystream_in=0x000102…0F at cycle 21; pt_data=0xFF…FF presented → ct_data=0xFFFEFD…F0, one cycle after the pt handshake.
- Four back-to-back launches, plaintext withheld → launch_ready=0 after the 4th; 5th launch attempt sets overflow=1 and no 5th keystream is captured.
- Stream of 8 blocks with ct_ready toggling 1,0,1,0 → no lost or duplicated blocks; ct_data order matches launch order; credit returns to 4.
- scan_enable=1, scan_ck_en=1 for 128 cycles shifting alternating 1/0 → pattern appears on scan_output after 128 cycles; FIFO count is unchanged on exit.
- CTR_PARTIAL_BLOCK_EN with pt_nbytes=5 → ct_data[87:0]=0 and the upper 40 bits equal keystream ^ plaintext.
